// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file.
// Sizes and the hardwired-zero register index.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file32_if.sv
// Read/write bundle of the register file.
// The master drives indices and write data, the slave returns operands.
interface register_file32_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic [DATA_W-1:0] dataIn;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;

    modport master (
        output dataIn,
        output rd,
        output rs1,
        output rs2,
        input  dataA,
        input  dataB
    );

    modport slave (
        input  dataIn,
        input  rd,
        input  rs1,
        input  rs2,
        output dataA,
        output dataB
    );

endinterface

// File: rtl/register32.sv
// One storage word with load enable.
// Cleared asynchronously while rst is high.
module register32 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Capture d on an enabled edge; reset wins over any edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file32.sv
// 2-read / 1-write integer register file, x0 hardwired to zero.
// Writes land on the writeEn rising edge; reads are combinational.
module register_file32
    import regfile_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic               writeEn,
    input  logic               r,
    register_file32_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:1]  wrEn;
    logic [DATA_W-1:0] regs [DEPTH];

    // One-hot write select; rd = x0 selects nothing.
    always_comb begin
        wrEn = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wrEn[i] = (bus.rd != ZERO_REG) && (bus.rd == ADDR_W'(i));
        end
    end

    assign regs[0] = '0;

    for (genvar g = 1; g < DEPTH; g++) begin : gReg
        register32 #(
            .DATA_W(DATA_W)
        ) uReg (
            .clk(writeEn),
            .rst(r),
            .en (wrEn[g]),
            .d  (bus.dataIn),
            .q  (regs[g])
        );
    end

    // Two independent read muxes with the x0 path forced to zero.
    always_comb begin
        bus.dataA = (bus.rs1 == ZERO_REG) ? '0 : regs[bus.rs1];
        bus.dataB = (bus.rs2 == ZERO_REG) ? '0 : regs[bus.rs2];
    end

endmodule

// File: tb/tb_register_file32.sv
// Self-checking bench for register_file32.
// Array model plus literal checks of directed vectors.
module tb_register_file32;

    logic writeEn;
    logic r;
    logic tick;
    logic started;

    int checks;
    int errors;

    logic [31:0] model [32];

    register_file32_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file32 dut (
        .writeEn(writeEn),
        .r      (r),
        .bus    (bus)
    );

    initial begin
        tick = 1'b0;
        forever #5 tick = ~tick;
    end

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model[idx];
    endfunction

    // Every sampling tick, both ports must equal the model.
    always @(posedge tick) begin
        if (started) begin
            checks++;
            if (bus.dataA !== expRead(bus.rs1) || bus.dataB !== expRead(bus.rs2)) begin
                errors++;
                $display("FAIL model rs1=%0d rs2=%0d got A=%h B=%h want A=%h B=%h",
                         bus.rs1, bus.rs2, bus.dataA, bus.dataB,
                         expRead(bus.rs1), expRead(bus.rs2));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic wrPulse(input logic [4:0] addr, input logic [31:0] data);
        @(negedge tick);
        bus.rd = addr;
        bus.dataIn = data;
        #2 writeEn = 1'b1;
        #1;
        if (!r && addr != 5'd0) model[addr] = data;
        #1 writeEn = 1'b0;
    endtask

    task automatic setRead(input logic [4:0] a, input logic [4:0] b);
        @(negedge tick);
        bus.rs1 = a;
        bus.rs2 = b;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        started = 1'b0;
        writeEn = 1'b0;
        bus.dataIn = '0;
        bus.rd = '0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        clearModel();

        r = 1'b1;
        #10 r = 1'b0;
        started = 1'b1;

        setRead(5'd1, 5'd31);
        chk("reset_a", bus.dataA, 32'h0);
        chk("reset_b", bus.dataB, 32'h0);

        wrPulse(5'd1, 32'h28111172);
        wrPulse(5'd2, 32'h22857572);
        setRead(5'd1, 5'd2);
        chk("basic_a", bus.dataA, 32'h28111172);
        chk("basic_b", bus.dataB, 32'h22857572);

        wrPulse(5'd0, 32'hFFFFFFFF);
        setRead(5'd0, 5'd2);
        chk("x0_a", bus.dataA, 32'h0);
        chk("x0_keep_b", bus.dataB, 32'h22857572);

        setRead(5'd3, 5'd1);
        bus.dataIn = 32'hDEADBEEF;
        bus.rd = 5'd3;
        #1;
        chk("nobypass_pre", bus.dataA, 32'h0);
        @(negedge tick);
        #2 writeEn = 1'b1;
        #1 model[3] = 32'hDEADBEEF;
        chk("nobypass_post", bus.dataA, 32'hDEADBEEF);
        bus.dataIn = 32'h12345678;
        #1;
        chk("hold_high", bus.dataA, 32'hDEADBEEF);
        writeEn = 1'b0;
        #1;
        chk("fall_edge", bus.dataA, 32'hDEADBEEF);

        setRead(5'd1, 5'd2);
        r = 1'b1;
        clearModel();
        #1;
        chk("rst_mid_a", bus.dataA, 32'h0);
        chk("rst_mid_b", bus.dataB, 32'h0);
        wrPulse(5'd1, 32'hCAFEF00D);
        #1;
        chk("rst_wr_drop", bus.dataA, 32'h0);
        @(negedge tick);
        r = 1'b0;
        #1;
        chk("rst_release", bus.dataA, 32'h0);

        wrPulse(5'd4, 32'h11111111);
        wrPulse(5'd4, 32'h22222222);
        setRead(5'd4, 5'd4);
        chk("last_wins", bus.dataA, 32'h22222222);

        for (int i = 1; i < 32; i++) begin
            wrPulse(5'(i), 32'hA5A50000 | 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            setRead(5'(i), 5'(i));
            chk("sweep_same_a", bus.dataA, (i == 0) ? 32'h0 : (32'hA5A50000 | 32'(i)));
            chk("sweep_same_b", bus.dataB, (i == 0) ? 32'h0 : (32'hA5A50000 | 32'(i)));
            setRead(5'(i), 5'(31 - i));
            chk("sweep_cross_b", bus.dataB, (i == 31) ? 32'h0 : (32'hA5A50000 | 32'(31 - i)));
        end

        @(negedge tick);
        @(negedge tick);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
